// File: rtl/parity_accum_bank.sv
// Bank of P parity words that XOR-accumulate K partial-product beats, then drain one per handshake.
// Optional all_zero flag port is built when PARITY_ZERO_FLAG_EN is defined.
module parity_accum_bank #(
  parameter int M  = 16,
  parameter int P  = 4,
  parameter int K  = 8,
  parameter int IW = $clog2(P),
  parameter int CW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_data,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          busy,
  output logic          done
`ifdef PARITY_ZERO_FLAG_EN
  ,
  output logic          all_zero
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t        state;
  logic [M-1:0]  words [P];
  logic [M-1:0]  nxt   [P];
  logic [CW-1:0] beat_cnt;
  logic [IW-1:0] rd_ptr;
  logic          accept;
  logic          take;

  assign accept   = in_valid & in_ready;
  assign take     = out_valid & out_ready;
  assign out_data = words[rd_ptr];
  assign out_idx  = rd_ptr;

  // Out-of-range indices match no word, so such beats only advance the counter.
  always_comb begin
    for (int unsigned i = 0; i < P; i++) begin
      nxt[i] = words[i];
      if (accept && in_idx == IW'(i))
        nxt[i] = words[i] ^ in_data;
    end
  end

`ifdef PARITY_ZERO_FLAG_EN
  logic nxt_zero;
  always_comb begin
    nxt_zero = 1'b1;
    for (int unsigned i = 0; i < P; i++)
      if (nxt[i] != '0)
        nxt_zero = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int unsigned i = 0; i < P; i++)
        words[i] <= '0;
      beat_cnt  <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PARITY_ZERO_FLAG_EN
      all_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < P; i++)
              words[i] <= '0;
            beat_cnt <= '0;
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef PARITY_ZERO_FLAG_EN
            all_zero <= 1'b0;
`endif
          end
        end
        ACCUM: begin
          if (accept) begin
            words    <= nxt;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CW'(K - 1)) begin
              state     <= DRAIN;
              rd_ptr    <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
`ifdef PARITY_ZERO_FLAG_EN
              all_zero  <= nxt_zero;
`endif
            end
          end
        end
        DRAIN: begin
          if (take) begin
            if (rd_ptr == IW'(P - 1)) begin
              state     <= IDLE;
              rd_ptr    <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/parity_accum_bank.md
Name: parity_accum_bank

Overview:
- Parametrised successor to the fixed M-bit parity register stage of the parallel quasi-cyclic encoding block.
- Holds P parity words of M bits each. Every word is cleared at block start. Each word XOR-accumulates the circulant partial products routed to it over K input beats.
- After the K-th beat, the words drain one per handshake to the codeword assembler.
- Sits between the circulant multiplier array and the output packer.

Parameters:
- M, 16, parity word width in bits (circulant size).
- P, 4, number of parity words in the bank (P >= 2).
- K, 8, input beats per codeword block (K >= 1).
- IW, $clog2(P), width of the word index.
- CW, $clog2(K+1), width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a block; honoured only in IDLE.
- in_valid  input  1  partial product present.
- in_ready  output  1  bank accepts a partial product.
- in_data  input  M  partial product to XOR into the selected word.
- in_idx  input  IW  target parity word index.
- out_valid  output  1  out_data holds a finished parity word.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  M  parity word currently being drained.
- out_idx  output  IW  index of the word on out_data.
- busy  output  1  high in ACCUM or DRAIN.
- done  output  1  one-cycle pulse after the last word is drained.

Behaviour:
- Reset (async, rst=1): state=IDLE, all P words=0, beat_cnt=0, rd_ptr=0; in_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0. Reset mid-block aborts the block; no done pulse is issued.
- Accept condition: an input beat is accepted when in_valid & in_ready. An output word is taken when out_valid & out_ready.
- State IDLE: in_ready=0, out_valid=0.
  - start=1 → next cycle: all words=0, beat_cnt=0, state=ACCUM.
- State ACCUM: in_ready=1.
  - Each accepted beat: word[in_idx] <= word[in_idx] ^ in_data; beat_cnt++.
  - If in_idx >= P: the beat is counted but the data is discarded; no word changes.
  - Accepting beat number K (beat_cnt==K-1 at acceptance) → state=DRAIN, rd_ptr=0. That beat's XOR is applied in the same edge.
  - in_valid=0 stalls indefinitely with no change.
  - start is ignored.
- State DRAIN: in_ready=0, out_valid=1.
  - out_data=word[rd_ptr] and out_idx=rd_ptr, driven directly from registers (zero latency).
  - out_data must be stable while out_valid=1 and out_ready=0.
  - Each output handshake: rd_ptr++.
  - Handshake at rd_ptr==P-1 → state=IDLE, done=1 for exactly one cycle, rd_ptr=0.
  - start is ignored.
- start coincident with the done cycle: honoured, since the state is already IDLE. Back-to-back blocks therefore incur a one-cycle IDLE bubble.
- Words are not cleared on drain; they hold their values until the next start or reset.
- Latency: first out_valid is 1 cycle after the K-th accepted beat. Minimum block time is 1 + K + P cycles.
- All XOR is bitwise, M bits wide; there is no carry and no width growth.

Optional Feature:
- Macro: PARITY_ZERO_FLAG_EN.
- Defined:
  - Adds output port all_zero (1 bit). Registered, reset 0.
  - On the edge that enters DRAIN, all_zero is set to 1 iff every word equals 0 after the final XOR. It holds until the next start, which clears it to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-ACCUM, M=16,P=4,K=8: assert rst after 3 beats → in_ready=0, busy=0, all words 0. A following start plus 8 beats drains only the new block's data.
- Basic block: start; beats idx0:0x00FF, idx1:0x1234, idx0:0x0F0F, idx2:0xAAAA, idx3:0x5555, idx1:0x1234, idx2:0x000F, idx3:0xFFFF; out_ready=1 → drains 0x0FF0, 0x0000, 0xAAA5, 0xAAAA with out_idx 0..3 on consecutive cycles; done pulses once.
- Backpressure: as basic block, but out_ready low for 5 cycles in DRAIN, then toggled 1/0 → out_data and out_idx held while stalled, each word appears exactly once, done follows the 4th handshake.
- Input stalls, plus start while busy: in_valid gaps of 0–3 cycles during ACCUM and a start pulse asserted in ACCUM and in DRAIN → results equal the basic block; start has no effect.
- Out-of-range index: K=8 beats with one beat using in_idx beyond P-1, possible only in a variant with P=3 and IW=2 (idx=3) → that beat is counted, DRAIN begins after 8 beats, words are unaffected by it.
- PARITY_ZERO_FLAG_EN: idx0 receives 0xBEEF twice and all other beats are 0x0000 → all_zero=1 at DRAIN entry. Repeat with one extra 0x0001 beat → all_zero=0.
